// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the two-requester SRAM arbiter: FSM states, requester count, op codes.
package sram_arbiter_pkg;

    localparam int N_REQ = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] RD   = 2'd2;
    localparam logic [1:0] RSP  = 2'd3;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Request/response handshakes plus memory pins of the arbiter; slave = arbiter side, master = requesters + memory.
interface sram_arbiter_if #(
    parameter int BW_DATA = 64,
    parameter int BW_ADDR = 6
);
    import sram_arbiter_pkg::*;

    logic [N_REQ-1:0]         i_req_valid;
    logic [N_REQ-1:0]         o_req_ready;
    logic [N_REQ-1:0]         i_req_wen;
    logic [N_REQ*BW_ADDR-1:0] i_req_addr;
    logic [N_REQ*BW_DATA-1:0] i_req_data;
    logic [N_REQ-1:0]         o_rsp_valid;
    logic [N_REQ-1:0]         i_rsp_ready;
    logic [BW_DATA-1:0]       o_rsp_data;
    logic [BW_ADDR-1:0]       o_mem_addr;
    logic [BW_DATA-1:0]       o_mem_data;
    logic                     o_mem_wen;
    logic                     o_mem_cen;
    logic                     o_mem_oen;
    logic [BW_DATA-1:0]       i_mem_data;
    logic                     o_busy;

    modport slave (
        input  i_req_valid, i_req_wen, i_req_addr, i_req_data, i_rsp_ready, i_mem_data,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_mem_addr, o_mem_data,
               o_mem_wen, o_mem_cen, o_mem_oen, o_busy
    );

    modport master (
        output i_req_valid, i_req_wen, i_req_addr, i_req_data, i_rsp_ready, i_mem_data,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_mem_addr, o_mem_data,
               o_mem_wen, o_mem_cen, o_mem_oen, o_busy
    );

endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, on contention the pointer picks.
// Purely combinational, no backpressure of its own.
module rr_arb2
    import sram_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_valid,
    input  logic             i_ptr,
    output logic [N_REQ-1:0] o_gnt
);

    always_comb begin
        o_gnt = i_valid;
        if (i_valid == 2'b11) begin
            o_gnt = i_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and access sequencer owning the single SRAM port; write rsp 2 cycles after accept, read 3.
// One transaction in flight; requests are refused while busy and a response is held until its owner is ready.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int BW_DATA = 64,
    parameter int BW_ADDR = 6
) (
    input  logic          i_clk,
    input  logic          i_rst,
    sram_arbiter_if.slave bus
);

    logic [1:0]         state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [BW_ADDR-1:0] addr_q, addr_d;
    logic [BW_DATA-1:0] data_q, data_d;
    logic [BW_DATA-1:0] rdata_q, rdata_d;
    logic               wen_q, wen_d;
    logic               owner_q, owner_d;

    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   req_ready;
    logic               win;

    rr_arb2 u_rr_arb2 (
        .i_valid (bus.i_req_valid),
        .i_ptr   (rr_ptr_q),
        .o_gnt   (gnt)
    );

    assign win = gnt[1];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        wen_d     = wen_q;
        owner_d   = owner_q;
        req_ready = '0;

        case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (|gnt) begin
                    state_d  = ACC;
                    owner_d  = win;
                    rr_ptr_d = ~win;
                    wen_d    = bus.i_req_wen[win];
                    addr_d   = win ? bus.i_req_addr[BW_ADDR +: BW_ADDR]
                                   : bus.i_req_addr[0 +: BW_ADDR];
                    // Read requests may leave their data lanes undriven; keep the old write data.
                    if (bus.i_req_wen[win] == OP_WR) begin
                        data_d = win ? bus.i_req_data[BW_DATA +: BW_DATA]
                                     : bus.i_req_data[0 +: BW_DATA];
                    end
                end
            end
            ACC: begin
                state_d = (wen_q == OP_WR) ? RSP : RD;
            end
            RD: begin
                state_d = RSP;
                rdata_d = bus.i_mem_data;
            end
            RSP: begin
                if (bus.i_rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            wen_q    <= 1'b0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            wen_q    <= wen_d;
            owner_q  <= owner_d;
        end
    end

    // Address and data pins follow the capture registers, so they hold between accesses.
    assign bus.o_req_ready = req_ready;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_data  = data_q;
    assign bus.o_mem_cen   = (state_q == ACC);
    assign bus.o_mem_wen   = (state_q == ACC) && (wen_q == OP_WR);
    assign bus.o_mem_oen   = ((state_q == ACC) && (wen_q == OP_RD)) || (state_q == RD);
    assign bus.o_rsp_valid = (state_q == RSP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.o_rsp_data  = ((state_q == RSP) && (wen_q == OP_RD)) ? rdata_q : '0;
    assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an SRAM model; expected responses go to a scoreboard checked by a monitor.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int BW_DATA = 64;
    localparam int BW_ADDR = 6;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;

    sram_arbiter_if #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) bus ();

    sram_arbiter #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    typedef struct {
        int          owner;
        logic [63:0] data;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          nchecks = 0;
    int          nerr    = 0;
    int          cyc     = 0;
    logic [63:0] ref_mem [64];
    logic [63:0] mem     [64];

    always @(posedge i_clk) cyc <= cyc + 1;

    // SRAM model: write on cen&wen, read data appears the cycle after cen&oen.
    always @(posedge i_clk) begin
        if (bus.o_mem_cen && bus.o_mem_wen) mem[bus.o_mem_addr] <= bus.o_mem_data;
        if (bus.o_mem_cen && bus.o_mem_oen && !bus.o_mem_wen) bus.i_mem_data <= mem[bus.o_mem_addr];
    end

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        logic ok;
        ok = (bus.o_req_ready === 2'b00) && (bus.o_rsp_valid === 2'b00) &&
             (bus.o_rsp_data === 64'h0) && (bus.o_mem_addr === 6'h0) &&
             (bus.o_mem_data === 64'h0) && (bus.o_mem_wen === 1'b0) &&
             (bus.o_mem_cen === 1'b0) && (bus.o_mem_oen === 1'b0) && (bus.o_busy === 1'b0);
        chk(ok, name, 64'({bus.o_req_ready, bus.o_rsp_valid, bus.o_mem_wen, bus.o_mem_cen,
                          bus.o_mem_oen, bus.o_busy, bus.o_mem_addr}), 64'h0);
    endtask

    // Monitor: latency on first appearance, stability while held, owner/data on handshake.
    bit          seen = 1'b0;
    logic [1:0]  hold_v;
    logic [63:0] hold_d;
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                seen = 1'b0;
            end else if (bus.o_rsp_valid !== 2'b00) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "spurious_rsp", 64'(bus.o_rsp_valid), 64'h0);
                end else begin
                    if (!seen) begin
                        seen   = 1'b1;
                        hold_v = bus.o_rsp_valid;
                        hold_d = bus.o_rsp_data;
                        chk((cyc - sb[0].acc_cyc) == sb[0].lat, "rsp_latency",
                            64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
                    end else begin
                        chk(bus.o_rsp_valid === hold_v && bus.o_rsp_data === hold_d, "rsp_stable",
                            bus.o_rsp_data, hold_d);
                    end
                    if ((bus.o_rsp_valid & bus.i_rsp_ready) != 2'b00) begin
                        chk(bus.o_rsp_valid === (sb[0].owner == 1 ? 2'b10 : 2'b01), "rsp_owner",
                            64'(bus.o_rsp_valid), 64'(sb[0].owner == 1 ? 2'b10 : 2'b01));
                        chk(bus.o_rsp_data === sb[0].data, "rsp_data", bus.o_rsp_data, sb[0].data);
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Returns one cycle after the accept edge, i.e. while the DUT is in ACC.
    task automatic do_req(input int k, input bit w, input logic [5:0] a, input logic [63:0] d);
        bit got;
        got = 1'b0;
        @(posedge i_clk); #1;
        bus.i_req_valid[k]                 = 1'b1;
        bus.i_req_wen[k]                   = w;
        bus.i_req_addr[k*BW_ADDR +: BW_ADDR] = a;
        bus.i_req_data[k*BW_DATA +: BW_DATA] = w ? d : 64'bx;
        for (int n = 0; n < 50; n++) begin
            @(negedge i_clk);
            if (bus.o_req_ready[k] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk(got && bus.o_req_ready === (k == 1 ? 2'b10 : 2'b01), "req_grant",
            64'(bus.o_req_ready), 64'(k == 1 ? 2'b10 : 2'b01));
        if (got) begin
            sb.push_back(exp_t'{owner: k, data: (w ? 64'h0 : ref_mem[a]), acc_cyc: cyc, lat: (w ? 2 : 3)});
            if (w) ref_mem[a] = d;
        end
        @(posedge i_clk); #1;
        bus.i_req_valid[k] = 1'b0;
    endtask

    // Both requesters present writes continuously; grants must alternate starting at req0.
    task automatic both_writes(input int n, input logic [5:0] a0, input logic [5:0] a1,
                               input logic [63:0] d0, input logic [63:0] d1);
        bit got;
        int k;
        @(posedge i_clk); #1;
        bus.i_req_valid = 2'b11;
        bus.i_req_wen   = 2'b11;
        bus.i_req_addr  = {a1, a0};
        bus.i_req_data  = {d1, d0};
        for (int g = 0; g < n; g++) begin
            got = 1'b0;
            k   = g % 2;
            for (int t = 0; t < 50; t++) begin
                @(negedge i_clk);
                chk(bus.o_req_ready !== 2'b11, "ready_onehot", 64'(bus.o_req_ready), 64'h0);
                if (bus.o_req_ready !== 2'b00) begin
                    got = 1'b1;
                    break;
                end
            end
            chk(got && bus.o_req_ready === (k == 1 ? 2'b10 : 2'b01), "rr_order",
                64'(bus.o_req_ready), 64'(k == 1 ? 2'b10 : 2'b01));
            if (got) begin
                sb.push_back(exp_t'{owner: k, data: 64'h0, acc_cyc: cyc, lat: 2});
                ref_mem[k == 1 ? a1 : a0] = (k == 1) ? d1 : d0;
            end
            @(posedge i_clk); #1;
        end
        bus.i_req_valid = 2'b00;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge i_clk);
        chk(sb.size() == 0, "drain", 64'(sb.size()), 64'h0);
    endtask

    logic [5:0]  c_addr [4];
    logic [63:0] c_val  [4];
    bit          got_v;

    initial begin
        bus.i_req_valid = 2'b00;
        bus.i_req_wen   = 2'b00;
        bus.i_req_addr  = '0;
        bus.i_req_data  = '0;
        bus.i_rsp_ready = 2'b11;
        c_addr = '{6'h00, 6'h10, 6'h20, 6'h3F};
        c_val  = '{64'h0000_1111_2222_3333, 64'h1010_1010_ABCD_0010,
                   64'h2020_2020_5A5A_0020, 64'hFFFF_0000_3F3F_003F};

        #1 i_rst = 1'b1;
        #2 chk_outputs_zero("reset_outputs");
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;

        // Contention straight out of reset: req0, req1, req0, req1.
        both_writes(4, 6'h01, 6'h02, 64'hA0A0_A0A0_0000_0001, 64'hB1B1_B1B1_0000_0002);
        wait_drain();

        // Single requester write then read.
        do_req(0, OP_WR, 6'h2A, 64'hDEAD_BEEF_0123_4567);
        @(negedge i_clk);
        chk(bus.o_mem_cen === 1'b1 && bus.o_mem_wen === 1'b1 && bus.o_mem_oen === 1'b0 &&
            bus.o_mem_addr === 6'h2A, "wr_acc_pins",
            64'({bus.o_mem_cen, bus.o_mem_wen, bus.o_mem_oen, bus.o_mem_addr}), 64'({3'b110, 6'h2A}));
        chk(bus.o_mem_data === 64'hDEAD_BEEF_0123_4567, "wr_acc_data", bus.o_mem_data, 64'hDEAD_BEEF_0123_4567);
        @(negedge i_clk);
        chk(bus.o_mem_cen === 1'b0 && bus.o_rsp_valid === 2'b01, "wr_rsp_cycle",
            64'({bus.o_mem_cen, bus.o_rsp_valid}), 64'h1);
        wait_drain();
        do_req(0, OP_RD, 6'h2A, 64'h0);
        @(negedge i_clk);
        chk(bus.o_mem_cen === 1'b1 && bus.o_mem_wen === 1'b0 && bus.o_mem_oen === 1'b1, "rd_acc_pins",
            64'({bus.o_mem_cen, bus.o_mem_wen, bus.o_mem_oen}), 64'b101);
        @(negedge i_clk);
        chk(bus.o_mem_cen === 1'b0 && bus.o_mem_oen === 1'b1 && bus.o_mem_addr === 6'h2A, "rd_rd_pins",
            64'({bus.o_mem_cen, bus.o_mem_oen, bus.o_mem_addr}), 64'({2'b01, 6'h2A}));
        wait_drain();

        // Bank corners from alternating requesters, then read back.
        for (int i = 0; i < 4; i++) begin
            do_req(i % 2, OP_WR, c_addr[i], c_val[i]);
            wait_drain();
        end
        for (int i = 0; i < 4; i++) begin
            do_req((i + 1) % 2, OP_RD, c_addr[i], 64'h0);
            wait_drain();
        end

        // Response backpressure on req1 with req0 pending.
        bus.i_rsp_ready = 2'b01;
        do_req(1, OP_RD, 6'h3F, 64'h0);
        bus.i_req_valid[0] = 1'b1;
        bus.i_req_wen[0]   = OP_RD;
        bus.i_req_addr[5:0] = 6'h10;
        got_v = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge i_clk);
            if (bus.o_rsp_valid[1] === 1'b1) begin
                got_v = 1'b1;
                break;
            end
        end
        chk(got_v, "bp_rsp_seen", 64'(bus.o_rsp_valid), 64'h2);
        repeat (5) begin
            @(negedge i_clk);
            chk(bus.o_req_ready === 2'b00 && bus.o_busy === 1'b1, "bp_hold",
                64'({bus.o_req_ready, bus.o_busy}), 64'h1);
        end
        @(posedge i_clk); #1;
        bus.i_rsp_ready    = 2'b11;
        bus.i_req_valid[0] = 1'b0;
        wait_drain();

        // Reset during RD of a req0 read (leaves the pointer at 1 without reset).
        do_req(0, OP_RD, 6'h2A, 64'h0);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        #1 chk_outputs_zero("midop_reset_outputs");
        sb.delete();
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        repeat (6) begin
            @(negedge i_clk);
            chk(bus.o_rsp_valid === 2'b00, "no_rsp_after_reset", 64'(bus.o_rsp_valid), 64'h0);
        end
        both_writes(2, 6'h05, 6'h06, 64'hC0C0_0000_0000_0005, 64'hD1D1_0000_0000_0006);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
